// File: rtl/main_fsm_pkg.sv
// Shared types and constants for the multicycle main controller.
// Build option: MAIN_FSM_LONGMUL_EN adds the long-multiply states.
package main_fsm_pkg;

  // State encodings are visible on the State debug port, so values are fixed.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
`ifdef MAIN_FSM_LONGMUL_EN
    EXECMUL  = 4'd10,
    MULWB    = 4'd11,
`endif
    UNKNOWN  = 4'd15
  } state_t;

  // ALUSrcB selections
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selections
  localparam logic [1:0] RES_REG = 2'b00;
  localparam logic [1:0] RES_IMM = 2'b01;
  localparam logic [1:0] RES_PC  = 2'b10;

  // One control word per state; all fields are raw requests.
  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       reg_w_hi;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_ctrl_dec.sv
// Combinational state-to-control-word table for the main controller.
// Build option: MAIN_FSM_LONGMUL_EN enables the EXECMUL/MULWB rows.
module main_fsm_ctrl_dec
  import main_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Everything defaults to 0; each state raises only the signals it uses.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_PC;
      end
      DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_PC;
      end
      MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl.result_src = RES_IMM;
        ctrl.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      EXECUTER: begin
        ctrl.alu_op = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ALUWB: begin
        ctrl.reg_w = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_PC;
        ctrl.branch     = 1'b1;
      end
`ifdef MAIN_FSM_LONGMUL_EN
      EXECMUL: begin
        ctrl.alu_op = 1'b1;
      end
      MULWB: begin
        ctrl.reg_w    = 1'b1;
        ctrl.reg_w_hi = 1'b1;
      end
`endif
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main controller: Moore FSM with next-state logic and state register.
// Build option: MAIN_FSM_LONGMUL_EN adds the EXECMUL -> MULWB long-multiply path;
// without it MulLong is ignored and RegWHi stays 0.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MulLong,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       RegWHi,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] State
);

  state_t state_q;
  state_t state_d;
  ctrl_t  dec_ctrl;
  ctrl_t  out_ctrl;

  // Only the immediate flag and load/store bit steer the sequence.
  logic [3:0] unused_funct;
  assign unused_funct = Funct[4:1];
`ifndef MAIN_FSM_LONGMUL_EN
  logic unused_mul_long;
  assign unused_mul_long = MulLong;
`endif

  // Next state; instruction fields are only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01: state_d = MEMADR;
          2'b10: state_d = BRANCH;
          2'b11: state_d = UNKNOWN;
          default: begin
            if (Funct[5]) begin
              state_d = EXECUTEI;
            end else begin
`ifdef MAIN_FSM_LONGMUL_EN
              state_d = MulLong ? EXECMUL : EXECUTER;
`else
              state_d = EXECUTER;
`endif
            end
          end
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
`ifdef MAIN_FSM_LONGMUL_EN
      EXECMUL:  state_d = MULWB;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // State register; reset drops straight back to FETCH, abandoning any instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  main_fsm_ctrl_dec u_ctrl_dec (
    .state (state_q),
    .ctrl  (dec_ctrl)
  );

  // Hold every control output low while reset is asserted, even though the state reads FETCH.
  always_comb begin
    out_ctrl = reset ? dec_ctrl : '0;
  end

  assign IRWrite   = out_ctrl.ir_write;
  assign AdrSrc    = out_ctrl.adr_src;
  assign ALUSrcA   = out_ctrl.alu_src_a;
  assign NextPC    = out_ctrl.next_pc;
  assign RegW      = out_ctrl.reg_w;
  assign MemW      = out_ctrl.mem_w;
  assign Branch    = out_ctrl.branch;
  assign ALUOp     = out_ctrl.alu_op;
  assign RegWHi    = out_ctrl.reg_w_hi;
  assign ALUSrcB   = out_ctrl.alu_src_b;
  assign ResultSrc = out_ctrl.result_src;
  assign State     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Testbench for main_fsm: directed scenarios plus random instruction streams,
// checked against an instruction-level model of state sequences and outputs.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       MulLong = 1'b0;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, RegWHi;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;

  int total = 0;
  int bad = 0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
  localparam int S_EXECMUL = 10, S_MULWB = 11, S_UNKNOWN = 15;

  typedef logic [3:0]  st_t;
  typedef logic [12:0] vec_t;

  int   exp_seq[$];
  st_t  st_obs[$];
  vec_t out_obs[$];

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MulLong   (MulLong),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .RegWHi    (RegWHi),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .State     (State)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Bundle all outputs in the order {IRWrite,AdrSrc,ALUSrcA,NextPC,RegW,MemW,Branch,ALUOp,RegWHi,ALUSrcB,ResultSrc}
  function automatic vec_t observed();
    return {IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, RegWHi, ALUSrcB, ResultSrc};
  endfunction

  // Per-state output table, straight from the controller description
  function automatic vec_t exp_out(int st);
    logic ir = 0, adr = 0, sa = 0, npc = 0, rw = 0, mw = 0, br = 0, aop = 0, rwhi = 0;
    logic [1:0] sb = 2'b00, res = 2'b00;
    case (st)
      S_FETCH:   begin ir = 1; npc = 1; sa = 1; sb = 2'b10; res = 2'b10; end
      S_DECODE:  begin sa = 1; sb = 2'b10; res = 2'b10; end
      S_MEMADR:  begin sb = 2'b01; end
      S_MEMRD:   begin adr = 1; end
      S_MEMWB:   begin res = 2'b01; rw = 1; end
      S_MEMWR:   begin adr = 1; mw = 1; end
      S_EXECR:   begin aop = 1; end
      S_EXECI:   begin aop = 1; sb = 2'b01; end
      S_ALUWB:   begin rw = 1; end
      S_BRANCH:  begin sb = 2'b01; res = 2'b10; br = 1; end
      S_EXECMUL: begin aop = 1; end
      S_MULWB:   begin rw = 1; rwhi = 1; end
      default:   begin end
    endcase
    return {ir, adr, sa, npc, rw, mw, br, aop, rwhi, sb, res};
  endfunction

  // Instruction-level model: the states an instruction visits, starting at its FETCH
  task automatic build_seq(input logic [1:0] op, input logic [5:0] funct, input logic ml);
    exp_seq.delete();
    exp_seq.push_back(S_FETCH);
    exp_seq.push_back(S_DECODE);
    case (op)
      2'b10: exp_seq.push_back(S_BRANCH);
      2'b11: exp_seq.push_back(S_UNKNOWN);
      2'b01: begin
        exp_seq.push_back(S_MEMADR);
        if (funct[0]) begin
          exp_seq.push_back(S_MEMRD);
          exp_seq.push_back(S_MEMWB);
        end else begin
          exp_seq.push_back(S_MEMWR);
        end
      end
      default: begin
        if (funct[5]) begin
          exp_seq.push_back(S_EXECI);
          exp_seq.push_back(S_ALUWB);
        end else begin
`ifdef MAIN_FSM_LONGMUL_EN
          if (ml) begin
            exp_seq.push_back(S_EXECMUL);
            exp_seq.push_back(S_MULWB);
          end else begin
            exp_seq.push_back(S_EXECR);
            exp_seq.push_back(S_ALUWB);
          end
`else
          exp_seq.push_back(S_EXECR);
          exp_seq.push_back(S_ALUWB);
`endif
        end
      end
    endcase
  endtask

  // Drive one instruction from its FETCH cycle and record n cycles of State and outputs.
  // Inputs are scrambled once the controller no longer needs them.
  task automatic drive_instr(input logic [1:0] op, input logic [5:0] funct, input logic ml, input int n);
    Op = op;
    Funct = funct;
    MulLong = ml;
    st_obs.delete();
    out_obs.delete();
    for (int i = 0; i < n; i++) begin
      st_obs.push_back(State);
      out_obs.push_back(observed());
      if (exp_seq[i] != S_FETCH && exp_seq[i] != S_DECODE && exp_seq[i] != S_MEMADR) begin
        Op = 2'($urandom);
        Funct = 6'($urandom);
        MulLong = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  // Outputs are all low and State is FETCH while reset is held
  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (State !== 4'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", State); end
    total++;
    if (observed() !== 13'd0) begin bad++; $display("[TB] FAIL reset_outputs got=%b want=0", observed()); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_load();
    build_seq(2'b01, 6'b000001, 1'b0);
    drive_instr(2'b01, 6'b000001, 1'b0, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      total++;
      if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL load_state[%0d] got=%0d want=%0d", i, st_obs[i], exp_seq[i]); end
      total++;
      if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL load_out[%0d] got=%b want=%b", i, out_obs[i], exp_out(exp_seq[i])); end
    end
  endtask

  task automatic test_store();
    build_seq(2'b01, 6'b000000, 1'b0);
    drive_instr(2'b01, 6'b000000, 1'b0, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      total++;
      if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL store_state[%0d] got=%0d want=%0d", i, st_obs[i], exp_seq[i]); end
      total++;
      if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL store_out[%0d] got=%b want=%b", i, out_obs[i], exp_out(exp_seq[i])); end
    end
  endtask

  // Immediate data-processing followed directly by a branch
  task automatic test_dp_branch();
    logic [1:0] ops[2];
    logic [5:0] fns[2];
    ops[0] = 2'b00; fns[0] = 6'b101000;
    ops[1] = 2'b10; fns[1] = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      build_seq(ops[k], fns[k], 1'b0);
      drive_instr(ops[k], fns[k], 1'b0, exp_seq.size());
      for (int i = 0; i < exp_seq.size(); i++) begin
        total++;
        if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL dpbr%0d_state[%0d] got=%0d want=%0d", k, i, st_obs[i], exp_seq[i]); end
        total++;
        if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL dpbr%0d_out[%0d] got=%b want=%b", k, i, out_obs[i], exp_out(exp_seq[i])); end
      end
    end
  endtask

  task automatic test_mullong();
    build_seq(2'b00, 6'b000000, 1'b1);
    drive_instr(2'b00, 6'b000000, 1'b1, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      total++;
      if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL mul_state[%0d] got=%0d want=%0d", i, st_obs[i], exp_seq[i]); end
      total++;
      if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL mul_out[%0d] got=%b want=%b", i, out_obs[i], exp_out(exp_seq[i])); end
    end
  endtask

  task automatic test_undefined();
    build_seq(2'b11, 6'b111111, 1'b1);
    drive_instr(2'b11, 6'b111111, 1'b1, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      total++;
      if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL undef_state[%0d] got=%0d want=%0d", i, st_obs[i], exp_seq[i]); end
      total++;
      if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL undef_out[%0d] got=%b want=%b", i, out_obs[i], exp_out(exp_seq[i])); end
    end
  endtask

  // Reset pulsed mid-store: MemW must vanish at once and never come back
  task automatic test_abort();
    build_seq(2'b01, 6'b000000, 1'b0);
    drive_instr(2'b01, 6'b000000, 1'b0, 3);
    total++;
    if (State !== 4'(S_MEMWR)) begin bad++; $display("[TB] FAIL abort_pre_state got=%0d want=%0d", State, S_MEMWR); end
    total++;
    if (MemW !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre_memw got=%b want=1", MemW); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (MemW !== 1'b0) begin bad++; $display("[TB] FAIL abort_memw got=%b want=0", MemW); end
    total++;
    if (State !== 4'd0) begin bad++; $display("[TB] FAIL abort_state got=%0d want=0", State); end
    total++;
    if (observed() !== 13'd0) begin bad++; $display("[TB] FAIL abort_outputs got=%b want=0", observed()); end
    @(posedge clk);
    #1;
    total++;
    if (observed() !== 13'd0 || State !== 4'd0) begin bad++; $display("[TB] FAIL abort_hold got=%b/%0d want=0/0", observed(), State); end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  // Random instruction stream issued back to back
  task automatic test_random();
    logic [1:0] op;
    logic [5:0] fn;
    logic       ml;
    for (int k = 0; k < 60; k++) begin
      op = 2'($urandom);
      fn = 6'($urandom);
      ml = 1'($urandom);
      build_seq(op, fn, ml);
      drive_instr(op, fn, ml, exp_seq.size());
      for (int i = 0; i < exp_seq.size(); i++) begin
        total++;
        if (st_obs[i] !== 4'(exp_seq[i])) begin bad++; $display("[TB] FAIL rand%0d_state[%0d] op=%b fn=%b ml=%b got=%0d want=%0d", k, i, op, fn, ml, st_obs[i], exp_seq[i]); end
        total++;
        if (out_obs[i] !== exp_out(exp_seq[i])) begin bad++; $display("[TB] FAIL rand%0d_out[%0d] op=%b fn=%b ml=%b got=%b want=%b", k, i, op, fn, ml, out_obs[i], exp_out(exp_seq[i])); end
      end
    end
  endtask

  initial begin
    $display("[TB] starting main_fsm bench");
    test_reset();
    test_load();
    test_store();
    test_dp_branch();
    test_mullong();
    test_undefined();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port Op, input, 2 bits: instruction class (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-004 The block SHALL have port Funct, input, 6 bits: Funct[5] is the immediate flag; Funct[0] is load(1)/store(0).
REQ-005 The block SHALL have port MulLong, input, 1 bit: the decoder flags a long multiply (64-bit result, high word to second register).
REQ-006 The block SHALL have outputs IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp and RegWHi, each 1 bit.
REQ-007 The block SHALL have outputs ALUSrcB and ResultSrc, each 2 bits.
REQ-008 The block SHALL have output State, 4 bits: current state encoding, for debug.
REQ-009 RegW, MemW, NextPC and RegWHi SHALL be raw requests; condition gating is applied downstream.

Function
REQ-010 The block SHALL be a Moore FSM; every output SHALL depend only on registered state (and reset, per REQ-022).
REQ-011 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, EXECMUL=10, MULWB=11, UNKNOWN=15.
REQ-012 Transitions from FETCH: always to DECODE.
REQ-013 Transitions from DECODE: Op=01 goes to MEMADR; Op=10 goes to BRANCH; Op=11 goes to UNKNOWN.
REQ-014 Transitions from DECODE for Op=00: Funct[5]=1 goes to EXECUTEI; Funct[5]=0 goes to EXECUTER, or to EXECMUL when MulLong=1 (see REQ-027).
REQ-015 Transitions from MEMADR: Funct[0]=1 goes to MEMRD; Funct[0]=0 goes to MEMWR.
REQ-016 Transitions SHALL also be: MEMRD to MEMWB; EXECUTER/EXECUTEI to ALUWB; EXECMUL to MULWB.
REQ-017 MEMWB, MEMWR, ALUWB, MULWB, BRANCH and UNKNOWN SHALL all go to FETCH; any unlisted encoding SHALL go to FETCH.
REQ-018 Output values not listed in REQ-019 SHALL be 0. Op/Funct/MulLong SHALL be sampled only in DECODE/MEMADR.
REQ-019 Outputs asserted per state:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUOp=1, ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- EXECMUL: ALUOp=1.
- MULWB: RegW=1, RegWHi=1.
- UNKNOWN: all outputs 0.
REQ-020 Instruction latency in cycles SHALL be: branch 3, data-processing 4, store 4, load 5, long multiply 4.

Reset
REQ-021 Asserting reset low SHALL immediately force State to FETCH, independent of clk.
REQ-022 While reset is low, all outputs SHALL be 0, including IRWrite and NextPC.
REQ-023 On the first rising clk edge after reset deasserts, the FSM SHALL be in FETCH with FETCH outputs; that edge SHALL transition to DECODE.
REQ-024 Reset asserted mid-instruction SHALL abort it; no pending RegW/MemW SHALL be issued afterwards.

Configuration
REQ-025 The macro MAIN_FSM_LONGMUL_EN SHALL compile the long-multiply path in or out.
REQ-026 When MAIN_FSM_LONGMUL_EN is undefined: MulLong is ignored, EXECMUL/MULWB do not exist, the MulLong=1 case goes to EXECUTER, and RegWHi is constant 0.
REQ-027 When MAIN_FSM_LONGMUL_EN is defined: the EXECMUL/MULWB path of REQ-014/016 is present.

Structure
REQ-028 A shared package main_fsm_pkg SHALL hold the state enum and named constants for ALUSrcB and ResultSrc encodings (REG=00, IMM=01, FOUR/PC=10).
REQ-029 The state-to-control-vector table SHALL be one combinational sub-module, main_fsm_ctrl_dec; next-state logic and the state register stay in main_fsm.

Verification
REQ-030 Scenario: release reset, Op=01, Funct=000001 -> State sequence 0,1,2,3,4,0; RegW=1 only in cycle 5 with ResultSrc=01.
REQ-031 Scenario: Op=01, Funct=000000 -> State sequence 0,1,2,5,0; MemW=1 for exactly one cycle with AdrSrc=1.
REQ-032 Scenario: Op=00, Funct=101000 then Op=10 -> sequence 0,1,7,8,0,1,9,0; Branch=1 only in state 9.
REQ-033 Scenario: Op=00, Funct[5]=0, MulLong=1 -> with the macro, 0,1,10,11,0 and RegW=RegWHi=1 in MULWB; without the macro, 0,1,6,8,0 and RegWHi always 0.
REQ-034 Scenario: Op=11 -> 0,1,15,0 with all outputs 0 in state 15; reset pulsed low during MEMWR -> MemW drops the same cycle and State=0.
